// File: rtl/fft_ctrl.sv
// Control and data-movement block for a 16-point radix-4 FFT: loads samples, sequences
// two butterfly passes through an external butterfly unit, and unloads results in digit-reversed order.
module fft_ctrl #(
  parameter int unsigned BF_LAT = 3,
  parameter int unsigned DW     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [2*DW-1:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [2*DW-1:0]   out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [8*DW-1:0]   bf_calc_in,
  output logic [2:0]        bf_rotation,
  input  logic [8*DW-1:0]   bf_calc_out
);

  localparam int unsigned SW  = 2 * DW;
  localparam int unsigned NPT = 16;
  localparam int unsigned NBF = 4;

  typedef enum logic [2:0] {
    IDLE, LOAD, S1_ISSUE, S1_DRAIN, S2_ISSUE, S2_DRAIN, UNLOAD
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                done_d;
  logic [SW-1:0]       mem_q [NPT];
  logic [SW-1:0]       mem_d [NPT];
  logic                pipe_v   [BF_LAT];
  logic                pipe_s2  [BF_LAT];
  logic [1:0]          pipe_idx [BF_LAT];
  logic                wb_v, wb_s2;
  logic [1:0]          wb_idx;
  logic                issue_d, issue_s2_d;
  logic [NBF*SW-1:0]   bf_in_d;
  logic                load_fire, out_fire;

  // Pass 1 strides by 4 across the array, pass 2 walks contiguous groups of 4.
  function automatic logic [3:0] bf_addr(input logic s2, input logic [1:0] idx, input logic [1:0] j);
    return s2 ? {idx, j} : {j, idx};
  endfunction

  function automatic logic [3:0] digit_rev(input logic [3:0] k);
    return {k[1:0], k[3:2]};
  endfunction

  assign wb_v      = pipe_v[BF_LAT-1];
  assign wb_s2     = pipe_s2[BF_LAT-1];
  assign wb_idx    = pipe_idx[BF_LAT-1];
  assign load_fire = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = 4'd0;
        end
      end
      LOAD: begin
        if (load_fire) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S1_ISSUE;
        end
      end
      S1_ISSUE: begin
        if (cnt_q == 4'd3) begin
          state_d = S1_DRAIN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S1_DRAIN: begin
        if (wb_v && !wb_s2 && wb_idx == 2'd3) state_d = S2_ISSUE;
      end
      S2_ISSUE: begin
        if (cnt_q == 4'd3) begin
          state_d = S2_DRAIN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S2_DRAIN: begin
        if (wb_v && wb_s2 && wb_idx == 2'd3) state_d = UNLOAD;
      end
      UNLOAD: begin
        if (out_fire) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_d    = (state_d == S1_ISSUE) || (state_d == S2_ISSUE);
  assign issue_s2_d = (state_d == S2_ISSUE);

  // Storage next value; a writeback landing this cycle is visible to reads issued this cycle.
  always_comb begin
    mem_d = mem_q;
    if (load_fire) mem_d[cnt_q] = in_data;
    if (wb_v) begin
      for (int j = 0; j < NBF; j++) begin
        mem_d[bf_addr(wb_s2, wb_idx, 2'(j))] = bf_calc_out[j*SW +: SW];
      end
    end
  end

  always_comb begin
    bf_in_d = '0;
    if (issue_d) begin
      for (int j = 0; j < NBF; j++) begin
        bf_in_d[j*SW +: SW] = mem_d[bf_addr(issue_s2_d, cnt_d[1:0], 2'(j))];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // State, counters, registered outputs and writeback address pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bf_calc_in  <= '0;
      bf_rotation <= 3'd0;
      for (int i = 0; i < BF_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_s2[i]  <= 1'b0;
        pipe_idx[i] <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready    <= (state_d == LOAD);
      busy        <= (state_d != IDLE);
      done        <= done_d;
      out_valid   <= (state_d == UNLOAD);
      out_data    <= (state_d == UNLOAD) ? mem_d[digit_rev(cnt_d)] : '0;
      bf_calc_in  <= bf_in_d;
      bf_rotation <= issue_d ? {issue_s2_d, cnt_d[1:0]} : 3'd0;
      pipe_v[0]   <= (state_q == S1_ISSUE) || (state_q == S2_ISSUE);
      pipe_s2[0]  <= (state_q == S2_ISSUE);
      pipe_idx[0] <= cnt_q[1:0];
      for (int i = 1; i < BF_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_s2[i]  <= pipe_s2[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

endmodule
